calc_result_display: RTL and testbench
======================================

Name: calc_result_display

Overview:
- Consumer end of the calculator `out` bus.
- Captures a 10-bit two's-complement calculator result on a load strobe.
- Converts it to sign plus three BCD digits with a sequential double-dabble engine, one iteration per clock.
- Drives a 4-digit multiplexed, active-low 7-segment display on the lab board.

Parameters:
- SCAN_DIV, 50000, clocks per digit-scan step; legal range 1..65535; scan counter is 16 bits.

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- result_in  input  10  calculator result, two's complement (-512..+511)
- load  input  1  capture strobe; sampled on rising clk
- busy  output  1  high while a conversion is in progress
- seg  output  7  cathodes, active-low, bit6..bit0 = g,f,e,d,c,b,a
- an  output  4  anodes, active-low one-hot; an[0] = rightmost digit

Behaviour:
- Clock and reset: one clock domain. Reset is asynchronous and active-low; clock and reset ports are clk and rst_n.
- Reset values:
  - State IDLE, busy=0.
  - Stored sign=0, hundreds/tens/ones=0.
  - Scan counter=0, digit index=0.
  - an=4'b1110, seg=7'b1000000 ('0').
- FSM states: IDLE, CONV, UPDATE.
- IDLE:
  - On an edge with load=1: capture sign=result_in[9] and mag=|result_in|, 10-bit unsigned.
  - -512 gives mag=512; no overflow.
  - Clear the 12-bit BCD accumulator, iteration count=0, go to CONV, busy=1.
- CONV, 10 cycles:
  - Each cycle, every BCD nibble >=5 gets +3.
  - Then shift {bcd,mag} left by 1.
  - After the 10th iteration, go to UPDATE.
- UPDATE:
  - Copy the BCD nibbles and sign into the display registers, go to IDLE, busy=0.
- Latency:
  - Load sampled at edge E0; busy high after E0 through E11 (11 cycles).
  - New digits are visible on seg/an after E11.
  - A new load is accepted at E12 at the earliest.
- load while busy=1, including the UPDATE cycle: ignored, no queuing.
- Display registers keep their previous value until UPDATE, so the display never shows partial results.
- Reset mid-conversion: conversion is abandoned and the display registers are cleared.
- Scan:
  - Counter counts 0..SCAN_DIV-1 and wraps.
  - At wrap, digit index advances 0→1→2→3→0.
  - SCAN_DIV=1 advances every clock.
- Digit mapping:
  - Index 0 = ones, 1 = tens, 2 = hundreds.
  - Index 3 = sign: 7'b0111111 (segment g only) if negative, blank 7'h7F if non-negative.
- an and seg are registered together so there is no ghosting between digits.
- Digit codes 0-9 are standard active-low. Nibble values >9 are unreachable; drive blank if they occur.

Optional Feature:
- Macro: CALC_LZ_BLANK_EN.
- Defined:
  - Hundreds digit is blanked when it is 0.
  - Tens digit is blanked when hundreds and tens are both 0.
  - Ones digit is always shown; the sign stays on digit 3.
  - Reset display is "   0".
- Undefined:
  - All three magnitude digits are always shown.
  - Reset display is " 000".

Test Plan (SCAN_DIV=4, macro undefined):
- Reset pulse -> busy=0, an=1110, seg=1000000; after 4 clocks an=1101.
- load with result_in=10'b0000000111 (+7) -> busy high exactly 11 cycles; then digits ones=7, tens=0, hundreds=0; digit 3 blank (7F).
- load with 10'b1111111111 (-1) -> digit 3 seg=0111111, digits 0,0,1. load with 10'b0000110110 (+54) -> digit 3 blank, digits 0,5,4.
- load with 10'b1000000000 (-512) -> "-512". load with 10'b0111111111 (+511) -> " 511".
- load +7, then load with -1 asserted on cycle 5 of busy -> second load ignored; display +7; busy drops after 11 cycles.
- Start a -512 load, assert rst_n=0 on cycle 6 -> busy=0 immediately; display " 000" after release.
- Rerun with CALC_LZ_BLANK_EN defined -> +7 shows hundreds/tens blank (7F); +54 shows only the hundreds digit blank.

Source files
------------

// File: rtl/calc_result_display.sv
// -----------------------------------------------------------------------------
// calc_result_display
//
// Consumer end of the calculator result bus. A 10-bit two's-complement result
// is captured on a load strobe, converted to sign + three BCD digits by a
// sequential double-dabble engine (one iteration per clock), and shown on a
// 4-digit multiplexed, active-low 7-segment display.
//
// Optional feature macro: CALC_LZ_BLANK_EN
//   defined   : leading-zero blanking of the hundreds and tens digits
//   undefined : all three magnitude digits are always shown
//
// Parameters:
//   SCAN_DIV   clocks per digit-scan step (1..65535)
//
// Ports:
//   clk        system clock, rising edge
//   rst_n      asynchronous active-low reset
//   result_in  calculator result, two's complement (-512..+511)
//   load       capture strobe, sampled on rising clk (ignored while busy)
//   busy       high while a conversion is in progress
//   seg        cathodes, active-low, bit6..bit0 = g,f,e,d,c,b,a
//   an         anodes, active-low one-hot, an[0] = rightmost digit
// -----------------------------------------------------------------------------
module calc_result_display #(
    parameter int unsigned SCAN_DIV = 50000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [9:0] result_in,
    input  logic       load,
    output logic       busy,
    output logic [6:0] seg,
    output logic [3:0] an
);

    localparam logic [15:0] SCAN_LAST = 16'(SCAN_DIV - 1);

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_MINUS = 7'b0111111;

    typedef enum logic [1:0] {
        IDLE,
        CONV,
        UPDATE
    } state_t;

    state_t      state_reg, state_next;
    logic [9:0]  mag_reg, mag_next;
    logic [11:0] bcd_reg, bcd_next;
    logic [3:0]  iter_reg, iter_next;
    logic        sign_reg, sign_next;

    logic [11:0] disp_bcd_reg, disp_bcd_next;
    logic        disp_sign_reg, disp_sign_next;

    logic [15:0] scan_cnt_reg, scan_cnt_next;
    logic [1:0]  digit_idx_reg, digit_idx_next;
    logic [6:0]  seg_reg, seg_next;
    logic [3:0]  an_reg, an_next;

    // Double-dabble add-3 correction, applied to each BCD nibble in parallel.
    logic [11:0] bcd_adj;
    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_adj
            assign bcd_adj[gi*4 +: 4] = (bcd_reg[gi*4 +: 4] >= 4'd5)
                                      ? bcd_reg[gi*4 +: 4] + 4'd3
                                      : bcd_reg[gi*4 +: 4];
        end
    endgenerate

    // {bcd,mag} shifted left by one. The top corrected bit is dropped: the
    // largest magnitude (512) never sets the hundreds nibble MSB.
    logic [21:0] shifted;
    assign shifted = {bcd_adj[10:0], mag_reg, 1'b0};

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            mag_reg       <= '0;
            bcd_reg       <= '0;
            iter_reg      <= '0;
            sign_reg      <= 1'b0;
            disp_bcd_reg  <= '0;
            disp_sign_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            mag_reg       <= mag_next;
            bcd_reg       <= bcd_next;
            iter_reg      <= iter_next;
            sign_reg      <= sign_next;
            disp_bcd_reg  <= disp_bcd_next;
            disp_sign_reg <= disp_sign_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        mag_next       = mag_reg;
        bcd_next       = bcd_reg;
        iter_next      = iter_reg;
        sign_next      = sign_reg;
        disp_bcd_next  = disp_bcd_reg;
        disp_sign_next = disp_sign_reg;
        case (state_reg)
            IDLE: begin
                if (load) begin
                    sign_next  = result_in[9];
                    // -512 negates to 10'b1000000000, which read unsigned is 512.
                    mag_next   = result_in[9] ? (~result_in + 10'd1) : result_in;
                    bcd_next   = '0;
                    iter_next  = '0;
                    state_next = CONV;
                end
            end
            CONV: begin
                bcd_next  = shifted[21:10];
                mag_next  = shifted[9:0];
                iter_next = iter_reg + 4'd1;
                if (iter_reg == 4'd9) begin
                    state_next = UPDATE;
                end
            end
            UPDATE: begin
                disp_bcd_next  = bcd_reg;
                disp_sign_next = sign_reg;
                state_next     = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    assign busy = (state_reg != IDLE);

    // ---------------------------------------------------------------- scan
    always_comb begin
        scan_cnt_next  = scan_cnt_reg + 16'd1;
        digit_idx_next = digit_idx_reg;
        if (scan_cnt_reg >= SCAN_LAST) begin
            scan_cnt_next  = '0;
            digit_idx_next = digit_idx_reg + 2'd1;
        end
    end

    function automatic logic [6:0] seg_decode(input logic [3:0] d);
        case (d)
            4'd0:    seg_decode = 7'b1000000;
            4'd1:    seg_decode = 7'b1111001;
            4'd2:    seg_decode = 7'b0100100;
            4'd3:    seg_decode = 7'b0110000;
            4'd4:    seg_decode = 7'b0011001;
            4'd5:    seg_decode = 7'b0010010;
            4'd6:    seg_decode = 7'b0000010;
            4'd7:    seg_decode = 7'b1111000;
            4'd8:    seg_decode = 7'b0000000;
            4'd9:    seg_decode = 7'b0010000;
            default: seg_decode = SEG_BLANK;
        endcase
    endfunction

    // seg/an are decoded from the *next* display values and digit index so
    // a result written in UPDATE is visible right after that same edge, and
    // anode and cathode change on the same edge.
    logic [3:0] hund_next, tens_next, ones_next;
    assign hund_next = disp_bcd_next[11:8];
    assign tens_next = disp_bcd_next[7:4];
    assign ones_next = disp_bcd_next[3:0];

    always_comb begin
        seg_next = SEG_BLANK;
        an_next  = ~(4'b0001 << digit_idx_next);
        case (digit_idx_next)
            2'd0: seg_next = seg_decode(ones_next);
`ifdef CALC_LZ_BLANK_EN
            2'd1: seg_next = (hund_next == 4'd0 && tens_next == 4'd0)
                             ? SEG_BLANK : seg_decode(tens_next);
            2'd2: seg_next = (hund_next == 4'd0) ? SEG_BLANK : seg_decode(hund_next);
`else
            2'd1: seg_next = seg_decode(tens_next);
            2'd2: seg_next = seg_decode(hund_next);
`endif
            2'd3: seg_next = disp_sign_next ? SEG_MINUS : SEG_BLANK;
            default: seg_next = SEG_BLANK;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scan_cnt_reg  <= '0;
            digit_idx_reg <= '0;
            seg_reg       <= 7'b1000000;
            an_reg        <= 4'b1110;
        end else begin
            scan_cnt_reg  <= scan_cnt_next;
            digit_idx_reg <= digit_idx_next;
            seg_reg       <= seg_next;
            an_reg        <= an_next;
        end
    end

    assign seg = seg_reg;
    assign an  = an_reg;

endmodule

// File: tb/tb_calc_result_display.sv
// -----------------------------------------------------------------------------
// tb_calc_result_display
//
// Directed testbench for calc_result_display with SCAN_DIV=4. Honours
// CALC_LZ_BLANK_EN for the expected leading-zero blanking.
// -----------------------------------------------------------------------------
module tb_calc_result_display;

    localparam logic [6:0] S0 = 7'b1000000;
    localparam logic [6:0] S1 = 7'b1111001;
    localparam logic [6:0] S2 = 7'b0100100;
    localparam logic [6:0] S4 = 7'b0011001;
    localparam logic [6:0] S5 = 7'b0010010;
    localparam logic [6:0] S7 = 7'b1111000;
    localparam logic [6:0] SB = 7'h7F;
    localparam logic [6:0] SM = 7'b0111111;

`ifdef CALC_LZ_BLANK_EN
    localparam logic LZ = 1'b1;
`else
    localparam logic LZ = 1'b0;
`endif

    logic       clk;
    logic       rst_n;
    logic [9:0] result_in;
    logic       load;
    logic       busy;
    logic [6:0] seg;
    logic [3:0] an;

    int checks = 0;
    int errors = 0;

    calc_result_display #(.SCAN_DIV(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .result_in (result_in),
        .load      (load),
        .busy      (busy),
        .seg       (seg),
        .an        (an)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check7(input string tag, input logic [6:0] got, input logic [6:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %b expected %b", tag, got, exp);
        end
        $display("check %s: seg=%b expected=%b", tag, got, exp);
    endtask

    task automatic check_int(input string tag, input int got, input int exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
        $display("check %s: value=%0d expected=%0d", tag, got, exp);
    endtask

    // Wait (bounded) until the requested digit is scanned, return its segments.
    // A timeout returns X, which fails the following comparison.
    task automatic read_digit(input int idx, output logic [6:0] s);
        logic [3:0] tgt;
        logic found;
        tgt   = ~(4'b0001 << idx);
        found = 1'b0;
        s     = 7'bx;
        for (int i = 0; i < 40 && !found; i++) begin
            if (an === tgt) begin
                s     = seg;
                found = 1'b1;
            end else begin
                @(posedge clk); #1;
            end
        end
    endtask

    task automatic check_display(input string tag, input logic [6:0] e3,
                                 input logic [6:0] e2, input logic [6:0] e1,
                                 input logic [6:0] e0);
        logic [6:0] s;
        read_digit(0, s); check7({tag, ".d0"}, s, e0);
        read_digit(1, s); check7({tag, ".d1"}, s, e1);
        read_digit(2, s); check7({tag, ".d2"}, s, e2);
        read_digit(3, s); check7({tag, ".d3"}, s, e3);
    endtask

    // Called at #1 after a posedge; load is sampled at the next edge (E0).
    task automatic do_load(input logic [9:0] v);
        result_in = v;
        load      = 1'b1;
        @(posedge clk); #1;
        load      = 1'b0;
    endtask

    // Counts samples (taken #1 after each edge starting after E0) with busy=1.
    task automatic count_busy(input int start, output int cnt);
        cnt = start;
        for (int i = 0; i < 40 && busy === 1'b1; i++) begin
            cnt++;
            @(posedge clk); #1;
        end
    endtask

    initial begin
        int cnt;
        rst_n     = 1'b0;
        load      = 1'b0;
        result_in = '0;

        // Reset state
        #12;
        check_int("rst.busy", int'(busy), 0);
        check_int("rst.an", int'(an), 4'b1110);
        check7("rst.seg", seg, S0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        check_int("scan.an_after4", int'(an), 4'b1101);

        // +7
        do_load(10'b0000000111);
        count_busy(0, cnt);
        check_int("p7.busy_cycles", cnt, 11);
        check_display("p7", SB, LZ ? SB : S0, LZ ? SB : S0, S7);

        // -1
        do_load(10'b1111111111);
        count_busy(0, cnt);
        check_int("m1.busy_cycles", cnt, 11);
        check_display("m1", SM, LZ ? SB : S0, LZ ? SB : S0, S1);

        // +54
        do_load(10'b0000110110);
        count_busy(0, cnt);
        check_display("p54", SB, LZ ? SB : S0, S5, S4);

        // -512
        do_load(10'b1000000000);
        count_busy(0, cnt);
        check_display("m512", SM, S5, S1, S2);

        // +511
        do_load(10'b0111111111);
        count_busy(0, cnt);
        check_display("p511", SB, S5, S1, S1);

        // +7 then -1 strobed on busy cycle 5: ignored
        do_load(10'b0000000111);
        cnt = 0;
        for (int i = 0; i < 40 && busy === 1'b1; i++) begin
            if (cnt == 4) begin
                result_in = 10'b1111111111;
                load      = 1'b1;
            end else begin
                load      = 1'b0;
            end
            cnt++;
            @(posedge clk); #1;
        end
        load = 1'b0;
        check_int("ign.busy_cycles", cnt, 11);
        repeat (3) @(posedge clk);
        #1;
        check_int("ign.busy_stays_low", int'(busy), 0);
        check_display("ign", SB, LZ ? SB : S0, LZ ? SB : S0, S7);

        // -512 with reset on busy cycle 6
        do_load(10'b1000000000);
        repeat (5) @(posedge clk);
        #1;
        check_int("rstmid.busy_before", int'(busy), 1);
        rst_n = 1'b0;
        #1;
        check_int("rstmid.busy", int'(busy), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check_display("rstmid", SB, LZ ? SB : S0, LZ ? SB : S0, S0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
